// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
package demux_pkg;

    // Width of the saturating dropped-beat counter.
    localparam int unsigned DROP_CNT_W = 8;

    // Select width for n channels. Never returns less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice for a single output channel of the demux.
module demux_slot #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          ZERO_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A slot being drained this cycle can accept a refill on the same edge.
    assign free      = !valid_q | out_ready;
    assign out_valid = valid_q;

    // Slot state: load has priority over drain so drain+refill keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Output payload: masked to zero when empty, or held, depending on build.
    always_comb begin
        out_data = data_q;
        if (ZERO_IDLE && !valid_q) begin
            out_data = '0;
        end
    end

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast mode.
module demux_stream_1xn
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned N         = 4,
    parameter int unsigned SELW      = clog2_min1(N),
    parameter bit          ZERO_IDLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*WIDTH-1:0]    out_data,
    output logic                  sel_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [N-1:0]          free;
    logic [N-1:0]          load;
    logic                  sel_ok;
    logic                  sel_free;
    logic                  accept;
    logic                  drop;
    logic                  sel_err_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Ready, per-slot load strobes and drop detection from the current select.
    always_comb begin
        sel_ok   = 32'(in_sel) < N;
        sel_free = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(in_sel) == k) begin
                sel_free = free[k];
            end
        end
        // An out-of-range select is always ready so the producer cannot deadlock.
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
        accept = in_valid & in_ready;
        for (int unsigned k = 0; k < N; k++) begin
            load[k] = accept & (in_bcast | (32'(in_sel) == k));
        end
        drop = accept & !in_bcast & !sel_ok;
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH     (WIDTH),
            .ZERO_IDLE (ZERO_IDLE)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .data_in   (in_data),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .free      (free[k])
        );
    end

    // Registered error pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q <= drop;
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign sel_err  = sel_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed self-checking bench: N=4 main build, N=3 invalid-select build, ZERO_IDLE=0 build.
module tb_demux_stream_1xn;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main build: N=4, WIDTH=4, ZERO_IDLE=1
    logic        a_valid, a_ready, a_bcast, a_err;
    logic [3:0]  a_data, a_ovalid, a_oready;
    logic [1:0]  a_sel;
    logic [15:0] a_odata;
    logic [7:0]  a_cnt;

    // N=3 build for out-of-range selects
    logic        b_valid, b_ready, b_bcast, b_err;
    logic [3:0]  b_data;
    logic [1:0]  b_sel;
    logic [2:0]  b_ovalid, b_oready;
    logic [11:0] b_odata;
    logic [7:0]  b_cnt;

    // ZERO_IDLE=0 build
    logic        z_valid, z_ready, z_bcast, z_err;
    logic [3:0]  z_data, z_ovalid, z_oready;
    logic [1:0]  z_sel;
    logic [15:0] z_odata;
    logic [7:0]  z_cnt;

    demux_stream_1xn #(.WIDTH(4), .N(4), .ZERO_IDLE(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sel(a_sel), .in_bcast(a_bcast), .out_valid(a_ovalid), .out_ready(a_oready),
        .out_data(a_odata), .sel_err(a_err), .drop_cnt(a_cnt)
    );

    demux_stream_1xn #(.WIDTH(4), .N(3), .ZERO_IDLE(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_sel(b_sel), .in_bcast(b_bcast), .out_valid(b_ovalid), .out_ready(b_oready),
        .out_data(b_odata), .sel_err(b_err), .drop_cnt(b_cnt)
    );

    demux_stream_1xn #(.WIDTH(4), .N(4), .ZERO_IDLE(1'b0)) u_dutz (
        .clk(clk), .rst_n(rst_n), .in_valid(z_valid), .in_ready(z_ready), .in_data(z_data),
        .in_sel(z_sel), .in_bcast(z_bcast), .out_valid(z_ovalid), .out_ready(z_oready),
        .out_data(z_odata), .sel_err(z_err), .drop_cnt(z_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_data = 0; a_sel = 0; a_bcast = 0; a_oready = 4'b0000;
        b_valid = 0; b_data = 0; b_sel = 0; b_bcast = 0; b_oready = 3'b111;
        z_valid = 0; z_data = 0; z_sel = 0; z_bcast = 0; z_oready = 4'b1111;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_ovalid", 64'(a_ovalid), 64'h0);
        chk("rst_odata", 64'(a_odata), 64'h0);
        chk("rst_cnt", 64'(a_cnt), 64'h0);
        chk("rst_err", 64'(a_err), 64'h0);

        // Fill slots 0 and 2, then reset mid-stream
        a_valid = 1; a_sel = 2'd0; a_data = 4'h3;
        step();
        a_sel = 2'd2; a_data = 4'h7;
        step();
        a_valid = 0;
        chk("fill_ovalid", 64'(a_ovalid), 64'h5);
        chk("fill_odata", 64'(a_odata), 64'h0703);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_ovalid", 64'(a_ovalid), 64'h0);
        chk("midrst_odata", 64'(a_odata), 64'h0);
        chk("midrst_cnt", 64'(a_cnt), 64'h0);

        // Unicast stream to channel 1
        a_oready = 4'b1111;
        a_valid = 1; a_sel = 2'd1; a_data = 4'hA;
        #1 chk("uni_ready0", 64'(a_ready), 64'h1);
        step();
        chk("uni_ovalid_a", 64'(a_ovalid), 64'h2);
        chk("uni_odata_a", 64'(a_odata), 64'h00A0);
        a_data = 4'hB;
        #1 chk("uni_ready1", 64'(a_ready), 64'h1);
        step();
        a_valid = 0;
        chk("uni_ovalid_b", 64'(a_ovalid), 64'h2);
        chk("uni_odata_b", 64'(a_odata), 64'h00B0);
        step();
        chk("uni_drained", 64'(a_ovalid), 64'h0);
        chk("uni_zero", 64'(a_odata), 64'h0);

        // Backpressure on channel 3
        a_oready = 4'b0111;
        a_valid = 1; a_sel = 2'd3; a_data = 4'h5;
        #1 chk("bp_ready_first", 64'(a_ready), 64'h1);
        step();
        chk("bp_ovalid_5", 64'(a_ovalid), 64'h8);
        chk("bp_odata_5", 64'(a_odata), 64'h5000);
        a_data = 4'h6;
        #1 chk("bp_ready_stall", 64'(a_ready), 64'h0);
        a_sel = 2'd0; a_data = 4'h2;
        #1 chk("bp_ready_ch0", 64'(a_ready), 64'h1);
        step();
        chk("bp_ovalid_ch0", 64'(a_ovalid), 64'h9);
        chk("bp_odata_ch0", 64'(a_odata), 64'h5002);
        a_sel = 2'd3; a_data = 4'h6;
        #1 chk("bp_ready_stall2", 64'(a_ready), 64'h0);
        step();
        chk("bp_ovalid_hold", 64'(a_ovalid), 64'h8);
        chk("bp_odata_hold", 64'(a_odata), 64'h5000);
        a_oready = 4'b1111;
        #1 chk("bp_ready_release", 64'(a_ready), 64'h1);
        step();
        a_valid = 0;
        chk("bp_ovalid_refill", 64'(a_ovalid), 64'h8);
        chk("bp_odata_refill", 64'(a_odata), 64'h6000);
        step();
        chk("bp_drained", 64'(a_ovalid), 64'h0);

        // Broadcast
        a_valid = 1; a_bcast = 1; a_sel = 2'd1; a_data = 4'hC;
        #1 chk("bc_ready_empty", 64'(a_ready), 64'h1);
        step();
        chk("bc_ovalid", 64'(a_ovalid), 64'hF);
        chk("bc_odata", 64'(a_odata), 64'hCCCC);
        a_oready = 4'b1011; a_data = 4'hD;
        #1 chk("bc_ready_stall", 64'(a_ready), 64'h0);
        step();
        chk("bc_ovalid_stall", 64'(a_ovalid), 64'h4);
        chk("bc_odata_stall", 64'(a_odata), 64'h0C00);
        chk("bc_ready_stall2", 64'(a_ready), 64'h0);
        a_oready = 4'b1111;
        #1 chk("bc_ready_release", 64'(a_ready), 64'h1);
        step();
        a_valid = 0; a_bcast = 0;
        chk("bc_ovalid_d", 64'(a_ovalid), 64'hF);
        chk("bc_odata_d", 64'(a_odata), 64'hDDDD);
        step();
        chk("bc_drained", 64'(a_ovalid), 64'h0);
        chk("main_no_err", 64'(a_err), 64'h0);
        chk("main_no_drop", 64'(a_cnt), 64'h0);

        // Invalid select on the N=3 build: 300 dropped beats
        b_valid = 1; b_sel = 2'd3; b_data = 4'hF;
        #1 chk("inv_ready", 64'(b_ready), 64'h1);
        step();
        chk("inv_err_first", 64'(b_err), 64'h1);
        chk("inv_cnt_first", 64'(b_cnt), 64'h1);
        chk("inv_ovalid_first", 64'(b_ovalid), 64'h0);
        for (int i = 2; i <= 300; i++) begin
            step();
            chk("inv_err_run", 64'(b_err), 64'h1);
            if (i == 100) chk("inv_cnt_100", 64'(b_cnt), 64'd100);
        end
        b_valid = 0;
        chk("inv_cnt_sat_run", 64'(b_cnt), 64'd255);
        step();
        chk("inv_err_end", 64'(b_err), 64'h0);
        chk("inv_cnt_sat", 64'(b_cnt), 64'd255);
        chk("inv_ovalid_end", 64'(b_ovalid), 64'h0);
        chk("inv_odata_end", 64'(b_odata), 64'h0);

        // ZERO_IDLE=0: drained channel keeps its last payload
        z_valid = 1; z_sel = 2'd0; z_data = 4'h9;
        step();
        z_valid = 0;
        chk("zi_ovalid", 64'(z_ovalid), 64'h1);
        chk("zi_odata", 64'(z_odata), 64'h0009);
        step();
        chk("zi_ovalid_drained", 64'(z_ovalid), 64'h0);
        chk("zi_odata_held", 64'(z_odata), 64'h0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
